// File: rtl/gol_board_mem_responder_if.sv
// Board memory bus: engine port S, host port H and the clear-sequencer controls.
interface gol_board_mem_responder_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 13
);
  logic [ADDR_W-1:0] s_address;
  logic              s_chipselect;
  logic              s_clken;
  logic              s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [DATA_W-1:0] s_readdata;

  logic [ADDR_W-1:0] h_address;
  logic              h_read;
  logic              h_write;
  logic [DATA_W-1:0] h_writedata;
  logic              h_waitrequest;
  logic [DATA_W-1:0] h_readdata;
  logic              h_readdatavalid;

  logic              clr_start;
  logic [ADDR_W-1:0] clr_base;
  logic [LEN_W-1:0]  clr_len;
  logic              clr_busy;
  logic              clr_done;
  logic              err_collision;

  modport master (
    output s_address, s_chipselect, s_clken, s_write, s_writedata,
    output h_address, h_read, h_write, h_writedata,
    output clr_start, clr_base, clr_len,
    input  s_readdata, h_waitrequest, h_readdata, h_readdatavalid,
    input  clr_busy, clr_done, err_collision
  );

  modport slave (
    input  s_address, s_chipselect, s_clken, s_write, s_writedata,
    input  h_address, h_read, h_write, h_writedata,
    input  clr_start, clr_base, clr_len,
    output s_readdata, h_waitrequest, h_readdata, h_readdatavalid,
    output clr_busy, clr_done, err_collision
  );
endinterface

// File: rtl/gol_board_mem_responder.sv
// Board image RAM for the Game-of-Life engine. Port S is the engine port and never stalls;
// port B is shared between host accesses and a clear sequencer that zeroes a board region.
module gol_board_mem_responder #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 13
) (
  input logic                      clock,
  input logic                      reset,
  gol_board_mem_responder_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  clr_len_sat;

  logic              s_access;
  logic              s_we;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              h_rd_accept;
  logic              done_d;
  logic              collision_d;

  logic [DATA_W-1:0] s_readdata_q;
  logic [DATA_W-1:0] h_readdata_q;
  logic              h_readdatavalid_q;
  logic              clr_done_q;
  logic              err_collision_q;

  logic [DATA_W-1:0] mem [DEPTH];

  assign s_access    = bus.s_chipselect & bus.s_clken;
  assign s_we        = s_access & bus.s_write;
  assign clr_len_sat = (bus.clr_len > LEN_MAX) ? LEN_MAX : bus.clr_len;
  assign collision_d = s_we & b_we & (bus.s_address == b_addr);

  // Port B arbitration: host owns it in idle, the clear sequencer owns it while clearing.
  always_comb begin
    state_d           = state_q;
    ptr_d             = ptr_q;
    cnt_d             = cnt_q;
    b_we              = 1'b0;
    b_addr            = bus.h_address;
    b_wdata           = bus.h_writedata;
    h_rd_accept       = 1'b0;
    done_d            = 1'b0;
    bus.h_waitrequest = 1'b0;
    unique case (state_q)
      StIdle: begin
        b_we        = bus.h_write;
        // Simultaneous read and write is a write only.
        h_rd_accept = bus.h_read & ~bus.h_write;
        if (bus.clr_start) begin
          if (clr_len_sat == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StClear;
            ptr_d   = bus.clr_base;
            cnt_d   = clr_len_sat;
          end
        end
      end
      StClear: begin
        bus.h_waitrequest = bus.h_read | bus.h_write;
        b_we              = 1'b1;
        b_addr            = ptr_q;
        b_wdata           = '0;
        ptr_d             = ptr_q + ADDR_W'(1);
        cnt_d             = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state; reset aborts any clear in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM writes; port S is applied last so it wins a same-address collision.
  always_ff @(posedge clock) begin
    if (b_we) begin
      mem[b_addr] <= b_wdata;
    end
    if (s_we) begin
      mem[bus.s_address] <= bus.s_writedata;
    end
  end

  // Registered read data and status pulses; reads see pre-write contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_readdata_q      <= '0;
      h_readdata_q      <= '0;
      h_readdatavalid_q <= 1'b0;
      clr_done_q        <= 1'b0;
      err_collision_q   <= 1'b0;
    end else begin
      if (s_access) begin
        s_readdata_q <= mem[bus.s_address];
      end
      if (h_rd_accept) begin
        h_readdata_q <= mem[bus.h_address];
      end
      h_readdatavalid_q <= h_rd_accept;
      clr_done_q        <= done_d;
      err_collision_q   <= collision_d;
    end
  end

  assign bus.s_readdata      = s_readdata_q;
  assign bus.h_readdata      = h_readdata_q;
  assign bus.h_readdatavalid = h_readdatavalid_q;
  assign bus.clr_busy        = (state_q == StClear);
  assign bus.clr_done        = clr_done_q;
  assign bus.err_collision   = err_collision_q;
endmodule

// File: tb/tb_gol_board_mem_responder.sv
// Bench for the board memory responder: directed scenarios plus random traffic, all checked
// against a word-array model with a queue of pending clear addresses.
module tb_gol_board_mem_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;

  gol_board_mem_responder_if bus ();

  gol_board_mem_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model.
  logic [7:0] m_mem [4096];
  int         clr_q [$];
  logic [7:0] e_srd;
  logic [7:0] e_hrd;
  bit         e_hrdv;
  bit         e_done;
  bit         e_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.s_address    = '0;
    bus.s_chipselect = 1'b0;
    bus.s_clken      = 1'b0;
    bus.s_write      = 1'b0;
    bus.s_writedata  = '0;
    bus.h_address    = '0;
    bus.h_read       = 1'b0;
    bus.h_write      = 1'b0;
    bus.h_writedata  = '0;
    bus.clr_start    = 1'b0;
    bus.clr_base     = '0;
    bus.clr_len      = '0;
  endtask

  // One clock of the model, evaluated with the inputs present at the edge.
  task automatic model_step();
    bit         s_acc;
    bit         s_wr;
    bit         b_wr;
    int         b_adr;
    logic [7:0] b_dat;
    logic [7:0] old_s;
    logic [7:0] old_h;
    int         n;
    s_acc  = bus.s_chipselect && bus.s_clken;
    s_wr   = s_acc && bus.s_write;
    b_wr   = 0;
    b_adr  = 0;
    b_dat  = '0;
    old_s  = m_mem[int'(bus.s_address)];
    old_h  = m_mem[int'(bus.h_address)];
    e_done = 0;
    e_hrdv = 0;
    e_err  = 0;
    if (clr_q.size() != 0) begin
      b_wr  = 1;
      b_adr = clr_q.pop_front();
      if (clr_q.size() == 0) e_done = 1;
    end else begin
      if (bus.h_write) begin
        b_wr  = 1;
        b_adr = int'(bus.h_address);
        b_dat = bus.h_writedata;
      end else if (bus.h_read) begin
        e_hrdv = 1;
        e_hrd  = old_h;
      end
      if (bus.clr_start) begin
        n = (int'(bus.clr_len) > 4096) ? 4096 : int'(bus.clr_len);
        if (n == 0) e_done = 1;
        for (int i = 0; i < n; i++) clr_q.push_back((int'(bus.clr_base) + i) % 4096);
      end
    end
    if (s_acc) e_srd = old_s;
    if (s_wr && b_wr && b_adr == int'(bus.s_address)) e_err = 1;
    if (b_wr) m_mem[b_adr] = b_dat;
    if (s_wr) m_mem[int'(bus.s_address)] = bus.s_writedata;
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic tick();
    #1;
    check_eq("h_waitrequest", bus.h_waitrequest,
             (clr_q.size() != 0) && (bus.h_read || bus.h_write));
    check_eq("clr_busy_pre", bus.clr_busy, clr_q.size() != 0);
    @(posedge clock);
    model_step();
    #1;
    check_eq("s_readdata", bus.s_readdata, e_srd);
    check_eq("h_readdatavalid", bus.h_readdatavalid, e_hrdv);
    if (e_hrdv) check_eq("h_readdata", bus.h_readdata, e_hrd);
    check_eq("clr_done", bus.clr_done, e_done);
    check_eq("err_collision", bus.err_collision, e_err);
    check_eq("clr_busy_post", bus.clr_busy, clr_q.size() != 0);
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    clr_q.delete();
    e_srd  = '0;
    e_hrd  = '0;
    e_hrdv = 0;
    e_done = 0;
    e_err  = 0;
    #1;
    check_eq("rst_s_readdata", bus.s_readdata, 0);
    check_eq("rst_h_readdata", bus.h_readdata, 0);
    check_eq("rst_h_rdv", bus.h_readdatavalid, 0);
    check_eq("rst_clr_busy", bus.clr_busy, 0);
    check_eq("rst_clr_done", bus.clr_done, 0);
    check_eq("rst_err", bus.err_collision, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic host_write(input int a, input int d);
    bus.h_address = 12'(a); bus.h_writedata = 8'(d); bus.h_write = 1'b1;
    tick();
    bus.h_write = 1'b0;
  endtask

  task automatic host_read(input int a);
    bus.h_address = 12'(a); bus.h_read = 1'b1;
    tick();
    bus.h_read = 1'b0;
  endtask

  task automatic s_access(input int a, input bit wr, input int d);
    bus.s_address = 12'(a); bus.s_writedata = 8'(d); bus.s_write = wr;
    bus.s_chipselect = 1'b1; bus.s_clken = 1'b1;
    tick();
    bus.s_chipselect = 1'b0; bus.s_clken = 1'b0; bus.s_write = 1'b0;
  endtask

  task automatic clear(input int base, input int len);
    bus.clr_base = 12'(base); bus.clr_len = 13'(len); bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
  endtask

  function automatic int pick_addr();
    return ($urandom_range(0, 11) + 4092) % 4096;
  endfunction

  initial begin
    int busy_cnt;
    int done_cnt;
    int wait_cnt;
    idle_inputs();
    @(negedge clock);
    apply_reset();

    // Whole-board clear with an oversized length, so every word is known.
    clear(0, 8000);
    for (int i = 0; i < 4096; i++) tick();
    check_eq("sat_busy_after", bus.clr_busy, 0);

    // 1: host write and read back.
    host_write(12'h010, 8'hA5);
    host_read(12'h010);
    check_eq("t1_rdv", bus.h_readdatavalid, 1);
    check_eq("t1_rd", bus.h_readdata, 8'hA5);

    // 2: port S write/read, then hold with clken low.
    s_access(12'h100, 1, 8'h3C);
    s_access(12'h100, 0, 0);
    check_eq("t2_rd", bus.s_readdata, 8'h3C);
    s_access(12'h010, 0, 0);
    bus.s_address = 12'h100; bus.s_chipselect = 1'b1; bus.s_clken = 1'b0;
    bus.s_write = 1'b1; bus.s_writedata = 8'h99;
    tick();
    check_eq("t2_hold", bus.s_readdata, 8'hA5);
    idle_inputs();
    s_access(12'h100, 0, 0);
    check_eq("t2_nowrite", bus.s_readdata, 8'h3C);

    // 3: wrapping clear of four words inside a 0xFF region.
    for (int a = 4091; a < 4096 + 5; a++) host_write(a % 4096, 8'hFF);
    busy_cnt = 0;
    done_cnt = 0;
    clear(12'hFFE, 4);
    busy_cnt += int'(bus.clr_busy);
    for (int i = 0; i < 5; i++) begin
      tick();
      busy_cnt += int'(bus.clr_busy);
      done_cnt += int'(bus.clr_done);
    end
    check_eq("t3_busy_cycles", busy_cnt, 4);
    check_eq("t3_done_pulses", done_cnt, 1);
    host_read(12'hFFD); check_eq("t3_fffd", bus.h_readdata, 8'hFF);
    host_read(12'hFFF); check_eq("t3_ffff", bus.h_readdata, 8'h00);
    host_read(12'h001); check_eq("t3_0001", bus.h_readdata, 8'h00);
    host_read(12'h002); check_eq("t3_0002", bus.h_readdata, 8'hFF);

    // 4: host read held across a clear.
    for (int a = 12'h040; a < 12'h043; a++) host_write(a, 8'h11);
    clear(12'h040, 3);
    wait_cnt = 0;
    bus.h_address = 12'h041; bus.h_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      wait_cnt += int'(bus.h_waitrequest);
      #0;
      tick();
    end
    bus.h_read = 1'b0;
    check_eq("t4_wait_cycles", wait_cnt, 3);
    check_eq("t4_rdv", bus.h_readdatavalid, 1);
    check_eq("t4_rd", bus.h_readdata, 8'h00);

    // 5: port S write collides with the clear write.
    host_write(12'h020, 8'h55);
    clear(12'h020, 1);
    s_access(12'h020, 1, 8'h77);
    check_eq("t5_err", bus.err_collision, 1);
    tick();
    check_eq("t5_err_once", bus.err_collision, 0);
    host_read(12'h020);
    check_eq("t5_rd", bus.h_readdata, 8'h77);

    // 6: zero-length clear, then reset in the middle of a long clear.
    clear(12'h300, 0);
    check_eq("t6_len0_done", bus.clr_done, 1);
    for (int a = 12'h200; a < 12'h210; a++) s_access(a, 1, 8'h5A);
    clear(12'h200, 100);
    for (int i = 0; i < 9; i++) tick();
    apply_reset();
    for (int i = 0; i < 3; i++) tick();
    for (int a = 12'h200; a < 12'h210; a++) host_read(a);
    host_read(12'h205); check_eq("t6_cleared", bus.h_readdata, 8'h00);
    host_read(12'h20C); check_eq("t6_untouched", bus.h_readdata, 8'h5A);

    // Random traffic around the wrap point.
    for (int i = 0; i < 1500; i++) begin
      bus.s_address    = 12'(pick_addr());
      bus.s_chipselect = ($urandom_range(0, 2) != 0);
      bus.s_clken      = ($urandom_range(0, 3) != 0);
      bus.s_write      = $urandom_range(0, 1) == 1;
      bus.s_writedata  = 8'($urandom);
      bus.h_address    = 12'(pick_addr());
      bus.h_read       = $urandom_range(0, 2) == 0;
      bus.h_write      = $urandom_range(0, 3) == 0;
      bus.h_writedata  = 8'($urandom);
      bus.clr_start    = $urandom_range(0, 15) == 0;
      bus.clr_base     = 12'(pick_addr());
      bus.clr_len      = 13'($urandom_range(0, 6));
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 10; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
